// File: rtl/mul_wb.sv
// Multiplier writeback buffer: queues {rd, low word, overflow} and retires in order to the RF port.
// Push-to-write latency is 1 cycle with no bypass; the head holds while alu_we owns the port, and in_ready drops when full.
module mul_wb #(
    parameter int N     = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_rd_addr,
    input  logic [N-1:0]             mul_rd,
    input  logic [N-1:0]             m_co,
    input  logic                     alu_we,
    input  logic                     clr_ovf,
    output logic                     rf_we,
    output logic [2:0]               rf_waddr,
    output logic [N-1:0]             rf_wdata,
    output logic                     ovf_flag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [2:0]   addr;
        logic [N-1:0] data;
        logic         ovf;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    assign head     = mem[rd_ptr];
    assign in_ready = (count < DEPTH_C);
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && !alu_we;

    // Address 0 still pops (and reports overflow) but never writes: r0 is hardwired.
    assign rf_we    = pop && (head.addr != 3'd0);
    assign rf_waddr = head.addr;
    assign rf_wdata = head.data;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: in_rd_addr, data: mul_rd, ovf: |m_co};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf_flag <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            // A retiring overflow beats a simultaneous clear.
            if (pop && head.ovf) begin
                ovf_flag <= 1'b1;
            end else if (clr_ovf) begin
                ovf_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mul_wb.sv
// Randomised and directed bench for mul_wb against a queue-based reference model.
module tb_mul_wb;

    localparam int N     = 16;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_rd_addr;
    logic [N-1:0]  mul_rd;
    logic [N-1:0]  m_co;
    logic          alu_we;
    logic          clr_ovf;
    logic          rf_we;
    logic [2:0]    rf_waddr;
    logic [N-1:0]  rf_wdata;
    logic          ovf_flag;
    logic [1:0]    count;

    mul_wb #(.N(N), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd_addr (in_rd_addr),
        .mul_rd     (mul_rd),
        .m_co       (m_co),
        .alu_we     (alu_we),
        .clr_ovf    (clr_ovf),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .ovf_flag   (ovf_flag),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        bit ovf;
    } ent_t;

    ent_t q[$];
    bit   m_ovf;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_writes;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, checks outputs against the model, then advances both.
    task automatic step(input bit v, input int a, input int d, input int co, input bit awe, input bit clr);
        bit exp_we;
        bit push;
        bit pop;
        ent_t e;
        in_valid   = v;
        in_rd_addr = a[2:0];
        mul_rd     = d[N-1:0];
        m_co       = co[N-1:0];
        alu_we     = awe;
        clr_ovf    = clr;
        #1;
        exp_we = (q.size() > 0) && !awe && (q[0].addr != 0);
        check("count", 32'(count), 32'(q.size()));
        check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        check("rf_we", 32'(rf_we), 32'(exp_we));
        check("ovf_flag", 32'(ovf_flag), 32'(m_ovf));
        if (exp_we) begin
            check("rf_waddr", 32'(rf_waddr), 32'(q[0].addr));
            check("rf_wdata", 32'(rf_wdata), 32'(q[0].data));
            n_writes++;
        end
        push = v && (q.size() < DEPTH);
        pop  = (q.size() > 0) && !awe;
        if (pop && q[0].ovf) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (pop) void'(q.pop_front());
        if (push) begin
            e.addr = a & 7;
            e.data = d & 16'hFFFF;
            e.ovf  = ((co & 16'hFFFF) != 0);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit awe);
        step(1'b0, 0, 0, 0, awe, 1'b0);
    endtask

    // Asynchronous reset applied away from the clock edge; outputs must clear immediately.
    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf", 32'(ovf_flag), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        m_ovf = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_rd_addr = '0; mul_rd = '0;
        m_co = '0; alu_we = 1'b0; clr_ovf = 1'b0; m_ovf = 1'b0; n_writes = 0;
        #2;
        apply_reset();
        @(posedge clk);
        #1;

        // Single push, written next cycle.
        step(1'b1, 3, 16'h0015, 0, 1'b0, 1'b0);
        #0;
        check("single_waddr", 32'(rf_waddr), 32'd3);
        check("single_wdata", 32'(rf_wdata), 32'h15);
        check("single_we", 32'(rf_we), 32'd1);
        idle(1'b0);

        // Three pushes under stall: third is dropped, then in-order drain.
        step(1'b1, 1, 16'h1111, 0, 1'b1, 1'b0);
        step(1'b1, 2, 16'h2222, 0, 1'b1, 1'b0);
        step(1'b1, 4, 16'h4444, 0, 1'b1, 1'b0);
        check("stall_count", 32'(count), 32'd2);
        check("stall_ready", 32'(in_ready), 32'd0);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        check("drain_count", 32'(count), 32'd0);

        // Overflow sets the sticky flag; set wins over a coincident clear.
        step(1'b1, 5, 16'h0000, 16'h0001, 1'b0, 1'b0);
        idle(1'b0);
        check("ovf_set", 32'(ovf_flag), 32'd1);
        step(1'b1, 6, 16'h0006, 16'h8000, 1'b0, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0, 1'b1);
        check("ovf_set_wins", 32'(ovf_flag), 32'd1);
        step(1'b0, 0, 0, 0, 1'b0, 1'b1);
        check("ovf_cleared", 32'(ovf_flag), 32'd0);

        // Address 0 pops without writing.
        step(1'b1, 0, 16'hDEAD, 0, 1'b0, 1'b0);
        idle(1'b0);
        check("r0_count", 32'(count), 32'd0);

        // Streaming: steady occupancy of 1, pointers wrap several times.
        n_writes = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 1 + (i % 7), 16'h0100 + i, 0, 1'b0, 1'b0);
        idle(1'b0);
        check("stream_writes", 32'(n_writes), 32'd10);

        // Reset during a full stall discards both entries.
        step(1'b1, 2, 16'hAAAA, 16'h0002, 1'b1, 1'b0);
        step(1'b1, 3, 16'hBBBB, 0, 1'b1, 1'b0);
        check("pre_rst_count", 32'(count), 32'd2);
        apply_reset();
        n_writes = 0;
        for (int i = 0; i < 4; i++) idle(1'b0);
        check("post_rst_writes", 32'(n_writes), 32'd0);

        // Randomised traffic with occasional mid-stream resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) apply_reset();
            step($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 16'hFFFF),
                 ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 16'hFFFF),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_wb.md
MUL_WB -- requirements
Module: mul_wb

Interface
REQ-001 Parameter: N, 16, data width of the multiplier result and carry-out words.
REQ-002 Parameter: DEPTH, 2, result buffer entries; legal values are powers of two, 2 or greater.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous and active-low.
REQ-005 Port: in_valid  input  1  the multiplier result and destination address are valid this cycle.
REQ-006 Port: in_ready  output  1  the buffer can accept a result this cycle.
REQ-007 Port: in_rd_addr  input  3  destination register index.
REQ-008 Port: mul_rd  input  N  low word of the product.
REQ-009 Port: m_co  input  N  carry-out (high) word of the product.
REQ-010 Port: alu_we  input  1  the ALU writeback owns the register-file port this cycle (priority writer).
REQ-011 Port: clr_ovf  input  1  clear the sticky overflow flag.
REQ-012 Port: rf_we  output  1  register-file write enable from this block.
REQ-013 Port: rf_waddr  output  3  register-file write address.
REQ-014 Port: rf_wdata  output  N  register-file write data.
REQ-015 Port: ovf_flag  output  1  sticky flag; set when a retired result had a nonzero m_co.
REQ-016 Port: count  output  $clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-017 The block shall store {in_rd_addr, mul_rd, ovf = |m_co} in a circular FIFO of DEPTH entries with separate read and write pointers.
REQ-018 The block shall set in_ready to (count < DEPTH), combinationally from registered state only.
REQ-019 A push shall occur on a rising edge when in_valid and in_ready are both 1; in_valid while full shall be ignored, with no overwrite and no error state.
REQ-020 The head entry shall retire (pop) on a rising edge when count > 0 and alu_we = 0.
REQ-021 The block shall drive rf_we = (count > 0) && !alu_we && (head addr != 0), combinationally.
REQ-022 A retiring entry with address 0 shall pop without a write, because r0 is hardwired to zero; its ovf bit shall still update ovf_flag.
REQ-023 rf_waddr and rf_wdata shall always present the head entry's address and data.
REQ-024 When alu_we = 1, the head shall be held and rf_we shall be 0; the stall has no maximum length.
REQ-025 A simultaneous push and pop shall leave count unchanged; a push into an empty buffer shall become visible at the head on the next cycle, giving a latency of 1 cycle with no bypass.
REQ-026 Both pointers shall wrap modulo DEPTH.
REQ-027 ovf_flag shall be set on a retire whose ovf = 1, and cleared on clr_flag... (signal clr_ovf) = 1; if both occur in the same cycle, the set shall win.
REQ-028 Write ordering to the register file shall be strictly FIFO.

Reset
REQ-029 While rst_n = 0, the block shall asynchronously set both pointers to 0, count to 0, ovf_flag to 0 and rf_we to 0, with in_ready = 1.
REQ-030 An rst_n assertion mid-stall or mid-stream shall discard all buffered entries, and no write shall be issued for them after release.
REQ-031 Buffer storage contents need no reset; rf_waddr and rf_wdata are don't-care while rf_we = 0.

Verification
REQ-032 Single push of (addr 3, mul_rd 0x0015, m_co 0), alu_we = 0 -> next cycle: rf_we = 1, waddr 3, wdata 0x0015, ovf_flag stays 0.
REQ-033 Push three results back-to-back with alu_we held at 1 -> count = 2, in_ready = 0, and the third push is dropped; release alu_we -> the first two are written in order on consecutive cycles, then count = 0.
REQ-034 Push (addr 5, mul_rd 0x0000, m_co 0x0001) -> it is written and ovf_flag = 1 the following cycle; then clr_ovf coinciding with the retire of another ovf = 1 entry -> ovf_flag stays 1.
REQ-035 Push an entry with addr 0 -> it is popped, rf_we stays 0, and count returns to 0.
REQ-036 Continuous push and pop for 10 cycles with alu_we = 0 -> count stays at 1, pointers wrap, and all 10 writes arrive in order.
REQ-037 Assert rst_n = 0 with count = 2 during an alu_we stall -> count = 0, ovf_flag = 0 and rf_we = 0 immediately; no stale writes occur after release.
